// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction memory between the IF-stage
// fetch path and the program-loader write port. One access is granted per cycle.
// By default the loader has strict priority. Fetch data returns one cycle after
// the grant, and a flush turns it into a NOP bubble.
// Optional build macro IMEM_ARB_FAIRNESS_EN adds a burst counter. It grants
// fetch after MAX_BURST loader wins while fetch waits.
module imem_arbiter #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              f_req_i,
  input  logic [31:0]       f_addr_i,
  input  logic              f_flush_i,
  output logic              f_gnt_o,
  output logic              f_stall_o,
  output logic              f_valid_o,
  output logic [31:0]       f_rdata_o,
  input  logic              l_req_i,
  input  logic [31:0]       l_addr_i,
  input  logic [31:0]       l_wdata_i,
  output logic              l_gnt_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StFetch, StLoad} state_e;

  state_e state_q, state_d;
  logic   f_gnt, l_gnt, burst_full;

  // Byte offset and bits beyond the memory depth are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr_i[31:ADDR_W+2], f_addr_i[1:0],
                              l_addr_i[31:ADDR_W+2], l_addr_i[1:0]};

`ifdef IMEM_ARB_FAIRNESS_EN
  logic [3:0] burst_cnt_q, burst_cnt_d;

  assign burst_full = (burst_cnt_q == 4'(MAX_BURST));

  // Count loader wins while fetch is waiting; any fetch grant or idle fetch clears.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!f_req_i || f_gnt) begin
      burst_cnt_d = 4'd0;
    end else if (l_gnt) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_cnt_q <= 4'd0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  logic [3:0] unused_max_burst;
  assign unused_max_burst = 4'(MAX_BURST);
  assign burst_full       = 1'b0;
`endif

  // Grant decode; everything is forced quiet while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_ni) begin
      f_gnt = f_req_i & (~l_req_i | burst_full);
      l_gnt = l_req_i & ~f_gnt;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state records what was granted this cycle; a flushed fetch leaves nothing pending.
  always_comb begin
    state_d = StIdle;
    if (f_gnt && !f_flush_i) begin
      state_d = StFetch;
    end else if (l_gnt) begin
      state_d = StLoad;
    end
  end

  // Outputs: memory drive from this cycle's grant, fetch response from last cycle's state.
  always_comb begin
    f_gnt_o     = f_gnt;
    l_gnt_o     = l_gnt;
    f_stall_o   = rst_ni & f_req_i & ~f_gnt;
    f_valid_o   = rst_ni & (state_q == StFetch) & ~f_flush_i;
    f_rdata_o   = f_valid_o ? mem_rdata_i : Nop;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (f_gnt) begin
      mem_en_o   = 1'b1;
      mem_addr_o = f_addr_i[ADDR_W+1:2];
    end else if (l_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = l_addr_i[ADDR_W+1:2];
      mem_wdata_o = l_wdata_i;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter with a synchronous single-port memory model.
module tb_imem_arbiter;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk, rst_n;
  logic        f_req, f_flush, f_gnt, f_stall, f_valid;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_gnt;
  logic [31:0] l_addr, l_wdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [64];

  int checks   = 0;
  int failures = 0;

  imem_arbiter #(.ADDR_W(6), .MAX_BURST(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .f_req_i     (f_req),
    .f_addr_i    (f_addr),
    .f_flush_i   (f_flush),
    .f_gnt_o     (f_gnt),
    .f_stall_o   (f_stall),
    .f_valid_o   (f_valid),
    .f_rdata_o   (f_rdata),
    .l_req_i     (l_req),
    .l_addr_i    (l_addr),
    .l_wdata_i   (l_wdata),
    .l_gnt_o     (l_gnt),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " f_gnt"}, {31'd0, f_gnt}, 32'd0);
    chk({tag, " l_gnt"}, {31'd0, l_gnt}, 32'd0);
    chk({tag, " f_stall"}, {31'd0, f_stall}, 32'd0);
    chk({tag, " f_valid"}, {31'd0, f_valid}, 32'd0);
    chk({tag, " mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, " mem_addr"}, {26'd0, mem_addr}, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " f_rdata"}, f_rdata, Nop);
  endtask

  // Single loader write, checked in its grant cycle.
  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    l_req = 1'b1; l_addr = addr; l_wdata = data;
    #1;
    chk("load l_gnt", {31'd0, l_gnt}, 32'd1);
    chk("load mem_we", {31'd0, mem_we}, 32'd1);
    chk("load mem_addr", {26'd0, mem_addr}, {24'd0, addr[9:2]} & 32'h3f);
    tick();
    l_req = 1'b0;
  endtask

  initial begin
    logic exp_f;
    rst_n = 1'b0; f_req = 1'b1; f_addr = 32'h4; f_flush = 1'b0;
    l_req = 1'b1; l_addr = 32'h8; l_wdata = 32'h1234_5678;
    #2;
    chk_reset_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1; f_req = 1'b0; l_req = 1'b0;
    tick();

    // Preload words 0..2 through the loader port.
    load(32'h0, 32'hA);
    load(32'h4, 32'hB);
    load(32'h8, 32'hC);

    // Uncontended back-to-back fetch.
    f_req = 1'b1; f_addr = 32'h0; #1;
    chk("fetch0 f_gnt", {31'd0, f_gnt}, 32'd1);
    chk("fetch0 f_stall", {31'd0, f_stall}, 32'd0);
    chk("fetch0 mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("fetch0 f_valid", {31'd0, f_valid}, 32'd0);
    tick();
    f_addr = 32'h4; #1;
    chk("fetch1 f_gnt", {31'd0, f_gnt}, 32'd1);
    chk("fetch1 mem_addr", {26'd0, mem_addr}, 32'd1);
    chk("fetch1 f_valid", {31'd0, f_valid}, 32'd1);
    chk("fetch1 f_rdata", f_rdata, 32'hA);
    tick();
    f_addr = 32'h8; #1;
    chk("fetch2 f_gnt", {31'd0, f_gnt}, 32'd1);
    chk("fetch2 f_stall", {31'd0, f_stall}, 32'd0);
    chk("fetch2 f_rdata", f_rdata, 32'hB);
    tick();
    f_req = 1'b0; #1;
    chk("fetch3 f_valid", {31'd0, f_valid}, 32'd1);
    chk("fetch3 f_rdata", f_rdata, 32'hC);
    chk("idle mem_en", {31'd0, mem_en}, 32'd0);
    chk("idle mem_addr", {26'd0, mem_addr}, 32'd0);
    tick();

    // Flush in the response cycle.
    f_req = 1'b1; f_addr = 32'h0; tick();
    f_req = 1'b0; f_flush = 1'b1; #1;
    chk("flush_resp f_valid", {31'd0, f_valid}, 32'd0);
    chk("flush_resp f_rdata", f_rdata, Nop);
    tick();
    f_flush = 1'b0; f_req = 1'b1; f_addr = 32'h4; #1;
    chk("after_flush f_gnt", {31'd0, f_gnt}, 32'd1);
    tick();
    f_req = 1'b0; #1;
    chk("after_flush f_valid", {31'd0, f_valid}, 32'd1);
    chk("after_flush f_rdata", f_rdata, 32'hB);
    tick();

    // Flush in the grant cycle.
    f_req = 1'b1; f_flush = 1'b1; f_addr = 32'h8; #1;
    chk("flush_gnt f_gnt", {31'd0, f_gnt}, 32'd1);
    tick();
    f_req = 1'b0; f_flush = 1'b0; #1;
    chk("flush_gnt f_valid", {31'd0, f_valid}, 32'd0);
    chk("flush_gnt f_rdata", f_rdata, Nop);
    tick();

    // Write then fetch the same word; upper and low address bits are ignored.
    l_req = 1'b1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF; #1;
    chk("wr l_gnt", {31'd0, l_gnt}, 32'd1);
    chk("wr mem_addr", {26'd0, mem_addr}, 32'd4);
    chk("wr mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    l_req = 1'b0; f_req = 1'b1; f_addr = 32'hFFFF_FF13; #1;
    chk("rd f_gnt", {31'd0, f_gnt}, 32'd1);
    chk("rd mem_addr", {26'd0, mem_addr}, 32'd4);
    chk("rd mem_we", {31'd0, mem_we}, 32'd0);
    chk("rd f_valid after load", {31'd0, f_valid}, 32'd0);
    tick();
    f_req = 1'b0; #1;
    chk("rd f_valid", {31'd0, f_valid}, 32'd1);
    chk("rd f_rdata", f_rdata, 32'hDEAD_BEEF);
    tick();

    // Contention for 10 cycles.
    f_req = 1'b1; f_addr = 32'h0; l_req = 1'b1; l_addr = 32'h20; l_wdata = 32'h5555_0000;
    for (int i = 0; i < 10; i++) begin
`ifdef IMEM_ARB_FAIRNESS_EN
      exp_f = (i % 5 == 4);
`else
      exp_f = 1'b0;
`endif
      #1;
      chk($sformatf("cont%0d f_gnt", i), {31'd0, f_gnt}, {31'd0, exp_f});
      chk($sformatf("cont%0d l_gnt", i), {31'd0, l_gnt}, {31'd0, ~exp_f});
      chk($sformatf("cont%0d f_stall", i), {31'd0, f_stall}, {31'd0, ~exp_f});
      tick();
    end
    f_req = 1'b0; l_req = 1'b0;
    tick();

    // Asynchronous reset while a fetch response is pending.
    f_req = 1'b1; f_addr = 32'h0; #1;
    chk("arst f_gnt", {31'd0, f_gnt}, 32'd1);
    tick();
    chk("arst pre f_valid", {31'd0, f_valid}, 32'd1);
    #2;
    rst_n = 1'b0; #1;
    chk_reset_outputs("arst");
    f_req = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst f_valid", {31'd0, f_valid}, 32'd0);
    f_req = 1'b1; f_addr = 32'h8; #1;
    chk("post_rst f_gnt", {31'd0, f_gnt}, 32'd1);
    tick();
    f_req = 1'b0; #1;
    chk("post_rst f_valid2", {31'd0, f_valid}, 32'd1);
    chk("post_rst f_rdata", f_rdata, 32'hC);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
